// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package stream_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Index width for an N-entry requester set; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    // NOTE: blocking assignments here so each iteration sees 'found' from the previous one.
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(N_REQ)) w_pos = w_pos - (IDX_W+1)'(N_REQ);
      if (!found && req[w_pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Burst-locked round-robin arbiter merging N_REQ valid/ready streams into one
// registered output stream; the lock is released on the accepted last beat.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int DATA_LENGHT = 16,
  parameter int N_REQ       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             cfg_en,
  input  logic [N_REQ-1:0]             i_valid,
  output logic [N_REQ-1:0]             i_ready,
  input  logic [N_REQ*DATA_LENGHT-1:0] i_data,
  input  logic [N_REQ-1:0]             i_last,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DATA_LENGHT-1:0]       o_data,
  output logic                         o_last,
  output logic [$clog2(N_REQ)-1:0]     o_src
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant;

  logic [IDX_W-1:0]       w_pick;
  logic                   w_found;
  logic                   w_out_free;
  logic                   w_accept;
  logic [DATA_LENGHT-1:0] w_beat_data;
  logic                   w_beat_last;
  logic [IDX_W-1:0]       w_next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (i_valid & cfg_en),
    .ptr   (r_ptr),
    .idx   (w_pick),
    .found (w_found)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free  = !o_valid || o_ready;
  assign w_beat_data = i_data[int'(r_grant)*DATA_LENGHT +: DATA_LENGHT];
  assign w_beat_last = i_last[r_grant];
  assign w_accept    = (r_state == ST_LOCKED) && i_valid[r_grant] && w_out_free;
  assign w_next_ptr  = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    i_ready = '0;
    if (r_state == ST_LOCKED) i_ready[r_grant] = w_out_free;
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register, including the data path, so a
    // discarded beat never leaks out after reset.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_src   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_beat_last) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        o_valid <= 1'b1;
        o_data  <= w_beat_data;
        o_last  <= w_beat_last;
        o_src   <= r_grant;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_LENGHT, default 16, meaning the width of each data beat.
REQ-002 SHALL have parameter N_REQ, default 4, meaning the number of requester ports; legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port cfg_en, input, N_REQ bits: per-requester arbitration enable.
REQ-006 SHALL have port i_valid, input, N_REQ bits: per-requester beat valid.
REQ-007 SHALL have port i_ready, output, N_REQ bits: per-requester beat accepted.
REQ-008 SHALL have port i_data, input, N_REQ x DATA_LENGHT bits: per-requester beat data.
REQ-009 SHALL have port i_last, input, N_REQ bits: marks the final beat of a burst.
REQ-010 SHALL have port o_valid, output, 1 bit: output beat valid.
REQ-011 SHALL have port o_ready, input, 1 bit: downstream ready.
REQ-012 SHALL have port o_data, output, DATA_LENGHT bits: output beat data.
REQ-013 SHALL have port o_last, output, 1 bit: last-beat marker for the output beat.
REQ-014 SHALL have port o_src, output, $clog2(N_REQ) bits: index of the requester that sourced the output beat.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-016 In IDLE with any (i_valid & cfg_en) bit set, SHALL register grant = first set index searched from ptr upward, wrapping at N_REQ-1 to 0, and SHALL enter LOCKED on the next edge.
REQ-017 In IDLE, i_ready SHALL be all zeros.
REQ-018 In LOCKED, i_ready[grant] SHALL equal (!o_valid | o_ready), and all other i_ready bits SHALL be 0.
REQ-019 A beat SHALL be accepted when i_valid[grant] & i_ready[grant] are both high; on that edge o_data, o_last and o_src SHALL load the granted beat's data, last marker and grant index, and o_valid SHALL become 1.
REQ-020 o_valid SHALL clear when o_ready=1 and no new beat is accepted in that cycle.
REQ-021 The output register SHALL hold o_valid, o_data, o_last and o_src stable while o_valid=1 & o_ready=0.
REQ-022 On acceptance of a beat with i_last=1, SHALL return to IDLE and set ptr = (grant+1) mod N_REQ.
REQ-023 Latency: i_valid rising in IDLE at cycle 0 SHALL give i_ready at cycle 1 and o_valid at cycle 2, when the output is free.
REQ-024 Between bursts SHALL insert exactly one IDLE cycle; within a burst SHALL sustain one beat per cycle while o_ready=1.
REQ-025 Deasserting cfg_en[grant] mid-burst SHALL NOT break the lock; the burst SHALL complete.
REQ-026 With no enabled valid requester, SHALL remain in IDLE with ptr unchanged.
REQ-027 A requester dropping i_valid mid-burst SHALL keep the lock, with no beats accepted until it resumes.

Reset
REQ-028 While rst_n=0 at a clock edge, SHALL set state=IDLE, ptr=0, grant=0, o_valid=0, o_last=0, o_src=0 and i_ready=0; o_data SHALL be 0.
REQ-029 Reset mid-burst SHALL discard the held output beat and the lock; arbitration SHALL restart from ptr=0.

Structure
REQ-030 The FSM state enum and the function computing the index width SHALL reside in the shared package stream_arb_pkg.
REQ-031 The round-robin search SHALL be a combinational sub-module rr_pick, with inputs req[N_REQ] and ptr and outputs idx and found.

Verification
REQ-032 Reset mid-burst: rst_n=0 for 1 cycle during a 4-beat burst -> o_valid=0 and i_ready=0 on the next cycle; the first grant afterwards goes to the lowest enabled requester.
REQ-033 Single requester: req2 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3) with o_ready=1 -> o_data sequence A1, A2, A3 on cycles 2–4, o_src=2, o_last only on A3.
REQ-034 Fairness: all 4 requesters continuously valid with 1-beat bursts, ptr=0 -> o_src sequence 0,1,2,3,0 with one idle cycle between beats.
REQ-035 Backpressure: o_ready=0 for 5 cycles mid-burst -> o_data held constant, i_ready[grant]=0, no beat lost or duplicated once o_ready returns to 1.
REQ-036 Enable masking: cfg_en=4'b1010 with all requesters valid -> only o_src 1 and 3 appear; clearing cfg_en[1] mid-burst still completes the burst.
